fprf_ss_seq: RTL and testbench
==============================

// Module: fprf_ss_seq
// PURPOSE
//  Savestate sequencer for the FPU register file (2 banks x 16 x 32b).
//  SAVE: walks FR0..FR15 of bank 0, then bank 1, through one fprf read port and
//  streams the words out on a valid/ready port.
//  RESTORE: takes words from a valid/ready stream and writes them back through
//  one fprf write port, in the same order.
//  Sits beside fprf, between the CPU core and the MiSTer savestate DMA.
//  busy is the CPU pipeline-freeze request.
// PARAMETERS
//  SAVE_BANK1  1  1: transfer both banks (32 words); 0: bank 0 only (16 words)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous reset, active-high
//  save_req     in   1   start SAVE; sampled only in IDLE
//  restore_req  in   1   start RESTORE; sampled only in IDLE
//  busy         out  1   1 while not IDLE (CPU freezes pipeline and FPRF writes)
//  done         out  1   one-cycle pulse at end of a SAVE or RESTORE
//  rf_rsrc      out  4   fprf read register index
//  rf_rbank     out  1   fprf read bank
//  rf_rdata     in   32  fprf read data (combinational from rf_rsrc/rf_rbank)
//  rf_wen       out  1   fprf write enable
//  rf_wdst      out  4   fprf write register index
//  rf_wbank     out  1   fprf write bank
//  rf_wdata     out  32  fprf write data
//  out_valid    out  1   save stream word valid
//  out_data     out  32  save stream word
//  out_ready    in   1   save stream consumer ready
//  in_valid     in   1   restore stream word valid
//  in_data      in   32  restore stream word
//  in_ready     out  1   restore stream ready; equals (state==RESTORE)
// BEHAVIOUR
//  - Word count: NW = SAVE_BANK1 ? 32 : 16.
//  - 5b index idx: bank=idx[4], reg=idx[3:0]. Order: b0 FR0..FR15, then b1 FR0..FR15.
//  - States: IDLE, SAVE, DRAIN, RESTORE, FIN.
//  - Reset: state=IDLE, idx=0. Outputs: busy=0, done=0, out_valid=0, out_data=0,
//    rf_wen=0, rf_wdst=0, rf_wbank=0, rf_wdata=0, in_ready=0.
//    rf_rsrc/rf_rbank follow idx (0/0).
//  - IDLE:
//    - save_req -> SAVE; else restore_req -> RESTORE. Both high: SAVE wins.
//    - idx cleared on entry to either. Requests outside IDLE are ignored.
//  - busy is registered: request sampled at edge N -> busy=1 in cycle N+1.
//  - SAVE:
//    - rf_rsrc=idx[3:0], rf_rbank=idx[4].
//    - Each cycle where (!out_valid || out_ready): capture rf_rdata into out_data,
//      set out_valid, idx++.
//    - After capturing word NW-1 -> DRAIN.
//    - out_data/out_valid stay stable while out_valid && !out_ready.
//  - DRAIN: on out_valid && out_ready -> out_valid=0, done=1 next cycle, IDLE.
//  - SAVE latency: first out_valid at N+2. With out_ready=1, one word per cycle;
//    last word at N+1+NW; done and busy=0 at N+2+NW.
//  - RESTORE:
//    - Each in_valid && in_ready handshake registers rf_wen=1,
//      rf_wdst=idx[3:0], rf_wbank=idx[4], rf_wdata=in_data; idx++.
//    - rf_wen is 0 in all other cycles.
//    - After handshake of word NW-1 -> FIN, with in_ready=0.
//  - FIN: the last rf_wen cycle. Next cycle: done=1, busy=0, IDLE.
//    The FPRF is fully updated when done is seen.
//  - done is asserted exactly once per completed operation. The done cycle
//    already reads IDLE, so a request in that cycle is accepted.
//  - idx never wraps mid-operation; termination is by count NW.
//  - rst mid-operation: return to IDLE in the next cycle, drop any pending word
//    (out_valid=0, rf_wen=0), no done. Registers already restored keep new values.
//  - This block does not arbitrate the FPRF ports; the CPU gives it exclusive
//    use while busy=1.
// TESTING
//  1. Preload b0[i]=0x3F80_0000+i, b1[i]=0x4000_0000+i; save_req at N, out_ready=1
//     -> 32 words in order; first at N+2; done at N+34; done pulses once.
//  2. Save with out_ready random 50% -> same 32-word sequence; no drop or duplicate;
//     out_data stable while stalled.
//  3. Restore 0xA5A5_0000+k, k=0..31, random in_valid gaps -> exactly 32 rf_wen
//     pulses; fprf b0[k]/b1[k-16] match; done after last write.
//  4. SAVE_BANK1=0: save -> 16 words; restore -> 16 writes; bank 1 unchanged.
//  5. save_req and restore_req in the same cycle -> SAVE runs.
//     restore_req during SAVE is ignored (no in_ready, no rf_wen).
//  6. rst after 10 restore handshakes -> next cycle busy=0, rf_wen=0, no done;
//     b0 FR0..FR9 hold new values; a following full save completes normally.

Source files
------------

// File: rtl/fprf_ss_seq.sv
// fprf_ss_seq: savestate sequencer for the FPU register file.
// SAVE streams FPRF bank 0 (and optionally bank 1) out through a valid/ready
// port; RESTORE writes a valid/ready stream back in the same order.
// busy asks the CPU to freeze its pipeline and keep its hands off the FPRF.
module fprf_ss_seq #(
    parameter bit SAVE_BANK1 = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        save_req,
    input  logic        restore_req,
    output logic        busy,
    output logic        done,
    output logic [3:0]  rf_rsrc,
    output logic        rf_rbank,
    input  logic [31:0] rf_rdata,
    output logic        rf_wen,
    output logic [3:0]  rf_wdst,
    output logic        rf_wbank,
    output logic [31:0] rf_wdata,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready
);

    // Index of the final word of a transfer; the walk ends on this count
    // rather than on idx wrapping.
    localparam logic [4:0] LAST_IDX = SAVE_BANK1 ? 5'd31 : 5'd15;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SAVE    = 3'd1;
    localparam logic [2:0] ST_DRAIN   = 3'd2;
    localparam logic [2:0] ST_RESTORE = 3'd3;
    localparam logic [2:0] ST_FIN     = 3'd4;

    logic [2:0]  state_q,     state_d;
    logic [4:0]  idx_q,       idx_d;
    logic        done_q,      done_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_data_q,  out_data_d;
    logic        rf_wen_q,    rf_wen_d;
    logic [3:0]  rf_wdst_q,   rf_wdst_d;
    logic        rf_wbank_q,  rf_wbank_d;
    logic [31:0] rf_wdata_q,  rf_wdata_d;

    // busy and in_ready decode the registered state, so they change one cycle
    // after the edge that accepted the request.
    assign busy      = (state_q != ST_IDLE);
    assign in_ready  = (state_q == ST_RESTORE);
    assign done      = done_q;
    assign rf_rsrc   = idx_q[3:0];
    assign rf_rbank  = idx_q[4];
    assign rf_wen    = rf_wen_q;
    assign rf_wdst   = rf_wdst_q;
    assign rf_wbank  = rf_wbank_q;
    assign rf_wdata  = rf_wdata_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Next-state logic: sequencing, stream handshakes and FPRF write staging.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d     = state_q;
        idx_d       = idx_q;
        done_d      = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        rf_wen_d    = 1'b0;
        rf_wdst_d   = rf_wdst_q;
        rf_wbank_d  = rf_wbank_q;
        rf_wdata_d  = rf_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (save_req) begin
                    state_d = ST_SAVE;
                    idx_d   = 5'd0;
                end else if (restore_req) begin
                    state_d = ST_RESTORE;
                    idx_d   = 5'd0;
                end
            end
            ST_SAVE: begin
                // The output register is free when empty or being consumed now.
                if (!out_valid_q || out_ready) begin
                    out_data_d  = rf_rdata;
                    out_valid_d = 1'b1;
                    idx_d       = idx_q + 5'd1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_RESTORE: begin
                // in_ready is implied by being in this state.
                if (in_valid) begin
                    rf_wen_d   = 1'b1;
                    rf_wdst_d  = idx_q[3:0];
                    rf_wbank_d = idx_q[4];
                    rf_wdata_d = in_data;
                    idx_d      = idx_q + 5'd1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                // The final write is on the FPRF port this cycle; report done
                // only once it has landed.
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; a reset drops any pending word.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= 5'd0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'd0;
            rf_wen_q    <= 1'b0;
            rf_wdst_q   <= 4'd0;
            rf_wbank_q  <= 1'b0;
            rf_wdata_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            rf_wen_q    <= rf_wen_d;
            rf_wdst_q   <= rf_wdst_d;
            rf_wbank_q  <= rf_wbank_d;
            rf_wdata_q  <= rf_wdata_d;
        end
    end

endmodule

// File: tb/tb_fprf_ss_seq.sv
// tb_fprf_ss_seq: drives two sequencers (SAVE_BANK1=0 and 1), each beside a
// behavioural FPRF, with randomized stream pacing. A per-cycle compare step
// checks the streamed words and FPRF writes against queues built from a
// shadow register-file model.
module tb_fprf_ss_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        preload = 1'b0;

    logic        save_req    [2];
    logic        restore_req [2];
    logic        busy        [2];
    logic        done        [2];
    logic [3:0]  rf_rsrc     [2];
    logic        rf_rbank    [2];
    logic [31:0] rf_rdata    [2];
    logic        rf_wen      [2];
    logic [3:0]  rf_wdst     [2];
    logic        rf_wbank    [2];
    logic [31:0] rf_wdata    [2];
    logic        out_valid   [2];
    logic [31:0] out_data    [2];
    logic        out_ready   [2];
    logic        in_valid    [2];
    logic [31:0] in_data     [2];
    logic        in_ready    [2];

    // Environment FPRF per instance [inst][bank][reg], and the bench's model of it.
    logic [31:0] rf     [2][2][16];
    logic [31:0] exp_rf [2][2][16];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int act      = 1;
    bit cmp_en   = 1'b0;
    bit no_wr    = 1'b0;

    logic [31:0] save_q [$];
    logic [36:0] wr_q   [$];
    int          done_cnt;
    int          t_start;
    int          first_v;
    int          done_k;
    logic        in_hs;
    logic        stall_prev = 1'b0;
    logic [31:0] stall_data;

    always #5 clk = ~clk;

    genvar g;
    for (g = 0; g < 2; g++) begin : g_inst
        fprf_ss_seq #(.SAVE_BANK1(g == 1)) dut (
            .clk        (clk),
            .rst        (rst),
            .save_req   (save_req[g]),
            .restore_req(restore_req[g]),
            .busy       (busy[g]),
            .done       (done[g]),
            .rf_rsrc    (rf_rsrc[g]),
            .rf_rbank   (rf_rbank[g]),
            .rf_rdata   (rf_rdata[g]),
            .rf_wen     (rf_wen[g]),
            .rf_wdst    (rf_wdst[g]),
            .rf_wbank   (rf_wbank[g]),
            .rf_wdata   (rf_wdata[g]),
            .out_valid  (out_valid[g]),
            .out_data   (out_data[g]),
            .out_ready  (out_ready[g]),
            .in_valid   (in_valid[g]),
            .in_data    (in_data[g]),
            .in_ready   (in_ready[g])
        );
        assign rf_rdata[g] = rf[g][rf_rbank[g]][rf_rsrc[g]];
    end

    // Behavioural FPRF: combinational read above, clocked write port here.
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (preload) begin
                for (int r = 0; r < 16; r++) begin
                    rf[u][0][r] <= 32'h3F80_0000 + 32'(r);
                    rf[u][1][r] <= 32'h4000_0000 + 32'(r);
                end
            end else if (rf_wen[u]) begin
                rf[u][rf_wbank[u]][rf_wdst[u]] <= rf_wdata[u];
            end
        end
    end

    function automatic int nw_of(input int u);
        return (u == 1) ? 32 : 16;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp_v);
        n_checks++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp_v, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Per-cycle comparison of the active instance against the model queues.
    task automatic compare_cycle();
        logic [31:0] w;
        logic [36:0] e;
        in_hs = in_valid[act] && in_ready[act];
        if (!cmp_en) return;
        if (out_valid[act] && out_ready[act]) begin
            if (save_q.size() == 0) fail_now("save_extra_word");
            else begin
                w = save_q.pop_front();
                check("save_word", out_data[act], w);
            end
        end
        if (stall_prev) begin
            check("stall_valid", out_valid[act], 1);
            check("stall_data", out_data[act], stall_data);
        end
        stall_prev = out_valid[act] && !out_ready[act];
        stall_data = out_data[act];
        if (rf_wen[act]) begin
            if (wr_q.size() == 0) fail_now("restore_extra_write");
            else begin
                e = wr_q.pop_front();
                check("restore_write", {rf_wbank[act], rf_wdst[act], rf_wdata[act]}, e);
            end
        end
        if (out_valid[act] && first_v < 0) first_v = cyc - t_start;
        if (done[act]) begin
            done_cnt++;
            done_k = cyc - t_start;
        end
        if (no_wr) begin
            check("in_ready_during_save", in_ready[act], 0);
            check("rf_wen_during_save", rf_wen[act], 0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_cycle();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic pulse_req(input int u, input logic s, input logic r);
        save_req[u]    = s;
        restore_req[u] = r;
        tick();
        save_req[u]    = 1'b0;
        restore_req[u] = 1'b0;
    endtask

    task automatic compare_rf(input int u);
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < 16; r++)
                check("fprf_contents", rf[u][b][r], exp_rf[u][b][r]);
    endtask

    // Full save; expected stream is the model FPRF in bank/register order.
    task automatic run_save(input int u, input bit rand_ready, input logic both, input bit poke);
        int guard = 0;
        save_q.delete();
        for (int i = 0; i < nw_of(u); i++) save_q.push_back(exp_rf[u][i / 16][i % 16]);
        done_cnt = 0; first_v = -1; done_k = -1; no_wr = 1'b1;
        out_ready[u] = rand_ready ? 1'($urandom % 2) : 1'b1;
        check("busy_before_req", busy[u], 0);
        pulse_req(u, 1'b1, both);
        t_start = cyc;
        check("busy_after_req", busy[u], 1);
        while (done_cnt == 0 && guard < 500) begin
            if (rand_ready) out_ready[u] = 1'($urandom % 2);
            restore_req[u] = (poke && guard == 5);
            tick();
            guard++;
        end
        restore_req[u] = 1'b0;
        if (guard >= 500) fail_now("save_timeout");
        check("busy_at_done", busy[u], 0);
        tick(); tick();
        check("save_done_once", done_cnt, 1);
        check("save_words_left", save_q.size(), 0);
        no_wr = 1'b0;
        out_ready[u] = 1'b0;
    endtask

    // Restore NW words (or stop with reset after n_stop handshakes).
    task automatic run_restore(input int u, input logic [31:0] base, input int n_stop);
        int k = 0;
        int guard = 0;
        wr_q.delete();
        done_cnt = 0;
        for (int i = 0; i < n_stop; i++) begin
            wr_q.push_back({i[4], i[3:0], base + 32'(i)});
            exp_rf[u][i / 16][i % 16] = base + 32'(i);
        end
        pulse_req(u, 1'b0, 1'b1);
        while (k < n_stop && guard < 2000) begin
            in_valid[u] = 1'($urandom % 2);
            in_data[u]  = base + 32'(k);
            tick();
            if (in_hs) k++;
            guard++;
        end
        in_valid[u] = 1'b0;
        if (guard >= 2000) fail_now("restore_timeout");
        if (n_stop < nw_of(u)) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            check("rst_busy", busy[u], 0);
            check("rst_rf_wen", rf_wen[u], 0);
            tick(); tick(); tick();
            check("rst_no_done", done_cnt, 0);
        end else begin
            guard = 0;
            while (done_cnt == 0 && guard < 100) begin
                tick();
                guard++;
            end
            if (guard >= 100) fail_now("restore_done_timeout");
            tick(); tick();
            check("restore_done_once", done_cnt, 1);
        end
        check("restore_writes_left", wr_q.size(), 0);
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            save_req[u] = 0; restore_req[u] = 0; out_ready[u] = 0;
            in_valid[u] = 0; in_data[u] = 0;
            for (int r = 0; r < 16; r++) begin
                exp_rf[u][0][r] = 32'h3F80_0000 + 32'(r);
                exp_rf[u][1][r] = 32'h4000_0000 + 32'(r);
            end
        end
        @(posedge clk); #1;
        preload = 1'b1;
        tick(); tick();
        preload = 1'b0;
        rst = 1'b0;

        // Reset state
        check("rst_busy_o", busy[1], 0);
        check("rst_done", done[1], 0);
        check("rst_out_valid", out_valid[1], 0);
        check("rst_out_data", out_data[1], 0);
        check("rst_rf_wen_o", rf_wen[1], 0);
        check("rst_rf_wdst", rf_wdst[1], 0);
        check("rst_rf_wbank", rf_wbank[1], 0);
        check("rst_rf_wdata", rf_wdata[1], 0);
        check("rst_in_ready", in_ready[1], 0);
        check("rst_rf_rsrc", rf_rsrc[1], 0);
        check("rst_rf_rbank", rf_rbank[1], 0);
        check("preload_b1_r7", rf[1][1][7], 32'h4000_0007);
        cmp_en = 1'b1;

        // 1: full-rate save, latency pinned
        act = 1;
        run_save(1, 1'b0, 1'b0, 1'b0);
        check("save_first_valid_lat", first_v, 1);
        check("save_done_lat", done_k, 33);

        // 2: save with random backpressure
        run_save(1, 1'b1, 1'b0, 1'b0);

        // 3: restore with random gaps
        run_restore(1, 32'hA5A5_0000, 32);
        compare_rf(1);
        check("restore_b0_r0", rf[1][0][0], 32'hA5A5_0000);
        check("restore_b1_r5", rf[1][1][5], 32'hA5A5_0015);

        // 4: single-bank instance
        act = 0;
        run_save(0, 1'b0, 1'b0, 1'b0);
        check("save16_done_lat", done_k, 17);
        run_restore(0, 32'h5A5A_0000, 16);
        compare_rf(0);
        check("bank1_untouched", rf[0][1][3], 32'h4000_0003);

        // 5: simultaneous requests and restore_req during save
        act = 1;
        run_save(1, 1'b1, 1'b1, 1'b1);

        // 6: reset mid-restore, then a normal save
        run_restore(1, 32'hC3C3_0000, 10);
        compare_rf(1);
        check("partial_b0_r9", rf[1][0][9], 32'hC3C3_0009);
        check("partial_b0_r10", rf[1][0][10], 32'hA5A5_000A);
        run_save(1, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
